// File: rtl/trans_pop_arb.sv
// rtl/trans_pop_arb.sv - round-robin pop arbiter merging four show-ahead queues
module trans_pop_arb #(
    parameter int DATA_SIZE = 12,
    parameter int CONT_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [3:0]           empty,
    input  logic [DATA_SIZE-1:0] data_in0,
    input  logic [DATA_SIZE-1:0] data_in1,
    input  logic [DATA_SIZE-1:0] data_in2,
    input  logic [DATA_SIZE-1:0] data_in3,
    output logic                 pop0,
    output logic                 pop1,
    output logic                 pop2,
    output logic                 pop3,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [1:0]           src_out,
    output logic                 valid_out,
    input  logic                 req,
    input  logic [2:0]           idx,
    output logic [CONT_SIZE-1:0] data_out_cont,
    output logic                 valid_cont
);

    typedef enum logic [1:0] {INIT, IDLE, ACTIVE} state_t;

    state_t               state;
    logic [1:0]           last;
    logic [CONT_SIZE-1:0] count [4];

    logic                 slot_free;
    logic                 any_ready;
    logic                 found;
    logic [1:0]           grant;
    logic [1:0]           cand;
    logic [DATA_SIZE-1:0] grant_data;
    logic [3:0]           pop;

    assign any_ready = (empty != 4'b1111);
    assign slot_free = (!valid_out || out_ready) && (state != INIT) && !init;

    // Search starts one past the last served queue; offset 4 wraps back to last itself.
    always_comb begin
        found = 1'b0;
        grant = last;
        cand  = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        grant_data = data_in0;
        case (grant)
            2'd0: grant_data = data_in0;
            2'd1: grant_data = data_in1;
            2'd2: grant_data = data_in2;
            2'd3: grant_data = data_in3;
            default: grant_data = data_in0;
        endcase
    end

    assign pop  = (slot_free && found) ? (4'b0001 << grant) : 4'b0000;
    assign pop0 = pop[0];
    assign pop1 = pop[1];
    assign pop2 = pop[2];
    assign pop3 = pop[3];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state         <= INIT;
            last          <= 2'd3;
            data_out      <= '0;
            src_out       <= 2'd0;
            valid_out     <= 1'b0;
            data_out_cont <= '0;
            valid_cont    <= 1'b0;
            for (int i = 0; i < 4; i++) count[i] <= '0;
        end else begin
            // Reads see the count before any increment made at this same edge.
            if (req && (idx <= 3'd3)) begin
                data_out_cont <= count[idx[1:0]];
                valid_cont    <= 1'b1;
            end else begin
                data_out_cont <= '0;
                valid_cont    <= 1'b0;
            end

            if (init) begin
                state     <= INIT;
                last      <= 2'd3;
                valid_out <= 1'b0;
                for (int i = 0; i < 4; i++) count[i] <= '0;
            end else begin
                case (state)
                    INIT: begin
                        last      <= 2'd3;
                        valid_out <= 1'b0;
                        for (int i = 0; i < 4; i++) count[i] <= '0;
                        state     <= IDLE;
                    end
                    default: begin
                        if (slot_free) begin
                            if (found) begin
                                data_out     <= grant_data;
                                src_out      <= grant;
                                valid_out    <= 1'b1;
                                last         <= grant;
                                count[grant] <= count[grant] + 1'b1;
                            end else begin
                                valid_out <= 1'b0;
                            end
                        end
                        if (state == IDLE && any_ready)
                            state <= ACTIVE;
                        else if (state == ACTIVE && !any_ready && (!valid_out || out_ready))
                            state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trans_pop_arb.sv
// tb/tb_trans_pop_arb.sv - self-checking bench for trans_pop_arb with a queue-level reference model
module tb_trans_pop_arb;

    localparam int DS = 12;
    localparam int CS = 5;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic [3:0]    empty;
    logic [DS-1:0] din [4];
    logic          pop0, pop1, pop2, pop3;
    logic          out_ready;
    logic [DS-1:0] data_out;
    logic [1:0]    src_out;
    logic          valid_out;
    logic          req;
    logic [2:0]    idx;
    logic [CS-1:0] data_out_cont;
    logic          valid_cont;

    always #5 clk = ~clk;

    trans_pop_arb #(.DATA_SIZE(DS), .CONT_SIZE(CS)) dut (
        .clk(clk), .reset_L(reset_L), .init(init), .empty(empty),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .out_ready(out_ready), .data_out(data_out), .src_out(src_out), .valid_out(valid_out),
        .req(req), .idx(idx), .data_out_cont(data_out_cont), .valid_cont(valid_cont)
    );

    // Queue contents seen by the arbiter and the abstract delivery model.
    logic [DS-1:0] q [4][$];
    bit            m_live;
    bit            m_valid;
    logic [DS-1:0] m_data;
    logic [1:0]    m_src;
    int            m_last;
    int            m_cnt [4];
    int            m_cont;
    bit            m_vcont;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_valid = 0; m_data = '0; m_src = 2'd0; m_last = 3;
        m_cont = 0; m_vcont = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic drive_q();
        for (int i = 0; i < 4; i++) begin
            empty[i] = (q[i].size() == 0);
            din[i]   = empty[i] ? DS'($urandom) : q[i][0];
        end
    endtask

    function automatic int exp_pop();
        if (!reset_L || !m_live || init || !(!m_valid || out_ready)) return -1;
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (m_last + k) % 4;
            if (q[j].size() > 0) return j;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid_out), 32'(m_valid));
        chk({tag, "_data"},  32'(data_out),  32'(m_data));
        chk({tag, "_src"},   32'(src_out),   32'(m_src));
        chk({tag, "_cont"},  32'(data_out_cont), 32'(m_cont));
        chk({tag, "_vcont"}, 32'(valid_cont), 32'(m_vcont));
    endtask

    // One clock: inputs already set at the falling edge; check pops, advance the model, check outputs.
    task automatic step();
        int p;
        logic [3:0] ep;
        drive_q();
        #1;
        p  = exp_pop();
        ep = (p >= 0) ? 4'(1 << p) : 4'b0000;
        chk("pop", 32'({pop3, pop2, pop1, pop0}), 32'(ep));
        @(posedge clk);
        #1;
        if (!reset_L) begin
            model_reset();
        end else begin
            if (req && idx <= 3'd3) begin
                m_cont = m_cnt[idx[1:0]] % 32; m_vcont = 1;
            end else begin
                m_cont = 0; m_vcont = 0;
            end
            if (init || !m_live) begin
                m_valid = 0; m_last = 3;
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                m_live = !init;
            end else if (!m_valid || out_ready) begin
                if (p >= 0) begin
                    m_data  = q[p].pop_front();
                    m_src   = 2'(p);
                    m_valid = 1;
                    m_last  = p;
                    m_cnt[p] = m_cnt[p] + 1;
                end else begin
                    m_valid = 0;
                end
            end
        end
        check_outputs("out");
        @(negedge clk);
    endtask

    task automatic async_reset_check();
        reset_L = 1'b0;
        #1;
        model_reset();
        chk("arst_pops",  32'({pop3, pop2, pop1, pop0}), 32'd0);
        check_outputs("arst");
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; out_ready = 1'b0; req = 1'b0; idx = 3'd0;
        model_reset();
        drive_q();
        @(negedge clk);
        step();
        step();

        reset_L = 1'b1; init = 1'b1;
        step();
        init = 1'b0;
        step();

        // Single queue holding two words
        q[2].push_back(12'hA5A);
        q[2].push_back(12'h123);
        out_ready = 1'b1;
        step();
        chk("r34_d0", 32'(data_out), 32'h0A5A);
        step();
        chk("r34_d1", 32'(data_out), 32'h0123);
        chk("r34_src", 32'(src_out), 32'd2);
        step();
        chk("r34_drain", 32'(valid_out), 32'd0);

        // All four queues busy: strict rotation
        for (int i = 0; i < 4; i++) begin
            q[i].push_back(DS'(12'h100 + i));
            q[i].push_back(DS'(12'h200 + i));
        end
        for (int n = 0; n < 9; n++) step();

        // Backpressure hold then resume
        for (int i = 0; i < 4; i++) q[i].push_back(DS'($urandom));
        step();
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) step();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) step();

        // Counter wrap on queue 1
        init = 1'b1; step();
        init = 1'b0; step();
        for (int n = 0; n < 33; n++) q[1].push_back(DS'(n));
        for (int n = 0; n < 35; n++) step();
        req = 1'b1; idx = 3'd1;
        step();
        chk("r37_cont", 32'(data_out_cont), 32'd1);
        chk("r37_vcont", 32'(valid_cont), 32'd1);
        idx = 3'd5;
        step();
        chk("r37_bad_cont", 32'(data_out_cont), 32'd0);
        chk("r37_bad_vcont", 32'(valid_cont), 32'd0);
        req = 1'b0;

        // init while holding a word
        for (int i = 0; i < 4; i++) begin
            q[i].push_back(DS'($urandom));
            q[i].push_back(DS'($urandom));
        end
        out_ready = 1'b0;
        step();
        init = 1'b1;
        step();
        chk("r38_valid", 32'(valid_out), 32'd0);
        init = 1'b0; req = 1'b1; idx = 3'd0;
        step();
        req = 1'b0; out_ready = 1'b1;
        step();

        // Asynchronous reset mid-stream
        step();
        async_reset_check();
        step();
        q[0].push_back(12'h777);
        reset_L = 1'b1;
        step();
        step();
        chk("r39_src", 32'(src_out), 32'd0);
        chk("r39_valid", 32'(valid_out), 32'd1);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++)
                if (q[i].size() < 6 && $urandom_range(2, 0) == 0) q[i].push_back(DS'($urandom));
            out_ready = ($urandom_range(3, 0) != 0);
            req       = $urandom_range(1, 0) == 1;
            idx       = 3'($urandom_range(7, 0));
            init      = ($urandom_range(63, 0) == 0);
            if ($urandom_range(299, 0) == 0) async_reset_check();
            else reset_L = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trans_pop_arb.md
TRANS_POP_ARB -- requirements
Module: trans_pop_arb

Interface
REQ-001 Parameter DATA_SIZE, default 12, width of each queue word.
REQ-002 Parameter CONT_SIZE, default 5, width of each per-queue delivery counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 init  input  1  synchronous re-initialisation request; high forces state INIT.
REQ-006 empty  input  4  per-queue empty flags from the four output queues; bit i is queue i.
REQ-007 data_in0..data_in3  input  DATA_SIZE each  show-ahead head word of queue i, valid whenever empty[i]=0.
REQ-008 pop0..pop3  output  1 each  combinational pop strobe to queue i.
REQ-009 out_ready  input  1  downstream ready to accept data_out.
REQ-010 data_out  output  DATA_SIZE  registered merged word.
REQ-011 src_out  output  2  registered index of the queue that supplied data_out.
REQ-012 valid_out  output  1  data_out/src_out hold a word.
REQ-013 req  input  1  counter read request.
REQ-014 idx  input  3  counter select; values 0-3 are legal.
REQ-015 data_out_cont  output  CONT_SIZE  registered counter read value.
REQ-016 valid_cont  output  1  data_out_cont is valid this cycle.

Function
REQ-017 FSM states SHALL be INIT, IDLE and ACTIVE; reset enters INIT.
REQ-018 In INIT: no pops; the module SHALL clear counters, set the RR pointer to 3 and clear valid_out; it SHALL go to IDLE at the first edge with init=0.
REQ-019 From any state, init=1 at an edge SHALL go to INIT, and any word held in data_out SHALL be dropped (valid_out=0).
REQ-020 IDLE->ACTIVE when empty!=4'b1111; ACTIVE->IDLE when empty=4'b1111 and (valid_out=0 or out_ready=1).
REQ-021 Slot free SHALL mean (valid_out=0 or out_ready=1) and state is not INIT and init=0.
REQ-022 When the slot is free and any queue is non-empty, exactly one popN SHALL assert: the first non-empty queue searching last+1, last+2, ... modulo 4.
REQ-023 At that edge: data_out<=data_inN, src_out<=N, valid_out<=1, last<=N, count[N]<=count[N]+1.
REQ-024 When the slot is free and all queues are empty, valid_out SHALL go to 0 at the edge.
REQ-025 When the slot is not free, data_out, src_out and valid_out SHALL hold, and no pop SHALL assert.
REQ-026 popN SHALL never assert while empty[N]=1.
REQ-027 Latency SHALL be one cycle from pop to valid_out; sustained throughput SHALL be one word per cycle with out_ready=1.
REQ-028 Counters SHALL be CONT_SIZE bits and wrap from 31 to 0 with no saturation.
REQ-029 On req=1 with idx<=3: at the next edge, data_out_cont<=count[idx[1:0]] (the pre-increment value if that queue is popped in the same cycle) and valid_cont<=1.
REQ-030 On req=1 with idx>3, or on req=0: data_out_cont<=0 and valid_cont<=0 at the next edge.
REQ-031 Counter reads SHALL be served in every state, including INIT, where they return 0.

Reset
REQ-032 reset_L=0 SHALL immediately force: state INIT, last=3, all counters 0, data_out=0, src_out=0, valid_out=0, data_out_cont=0, valid_cont=0, and pop0..3=0.
REQ-033 Reset asserted mid-transfer SHALL drop the held word; no pop SHALL be issued until reset_L=1, init=0 and state IDLE has been reached.

Verification
REQ-034 Reset, init pulse, then queue 2 alone holds 0xA5A and 0x123 with out_ready=1 -> pop2 in two consecutive cycles; data_out 0xA5A then 0x123, src_out=2; then valid_out=0.
REQ-035 All four queues non-empty, out_ready=1 -> pop order 0,1,2,3,0,...; one word per cycle.
REQ-036 valid_out=1 with out_ready=0 for 3 cycles -> data_out stable, no pops; delivery resumes on the cycle out_ready rises.
REQ-037 33 words popped from queue 1, then req=1 with idx=1 -> data_out_cont=1 (wrapped), valid_cont=1; idx=5 -> data_out_cont=0, valid_cont=0.
REQ-038 init=1 while valid_out=1 and queues are non-empty -> valid_out=0 next cycle, counters 0, no pops until init=0 plus one cycle.
REQ-039 reset_L low mid-stream -> all outputs 0 asynchronously; after release, round-robin restarts at queue 0.
